// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one load/store per valid/ready handshake,
// performed against a reset-cleared word RAM after LATENCY wait states.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]             state;
    logic [3:0]             cnt;
    logic                   wr_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic                   err_q;
    logic [DEPTH-1:0][31:0] ram;

    // Decoded from the latched address only; request inputs may move after acceptance.
    logic          addr_err;
    logic [AW-1:0] widx;
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
    assign widx     = addr_q[AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ram     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= 4'(LATENCY);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                        err_q <= addr_err;
                        if (addr_err) begin
                            rdata_q <= '0;
                        end else if (wr_q) begin
                            ram[widx] <= wdata_q;
                            rdata_q   <= '0;
                        end else begin
                            rdata_q <= ram[widx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY=2 and LATENCY=0) checked
// every cycle against a transaction-level model plus directed literal expectations.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid[2];
    logic        req_ready[2];
    logic        req_write[2];
    logic [31:0] req_addr[2];
    logic [31:0] req_wdata[2];
    logic        resp_valid[2];
    logic        resp_ready[2];
    logic [31:0] resp_rdata[2];
    logic        resp_err[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(64), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    // Transaction-level model: a request accepted at edge e is performed at edge e+1+LATENCY.
    int          cyc = 0;
    int          mphase[2];
    int          mdue[2];
    logic        mwr[2];
    logic [31:0] maddr[2];
    logic [31:0] mwd[2];
    logic [31:0] mrd[2];
    logic        merr[2];
    logic [31:0] mmem[2][64];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mphase[k] <= 0;
                mrd[k]    <= '0;
                merr[k]   <= 1'b0;
                for (int w = 0; w < 64; w++) mmem[k][w] <= '0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < 2; k++) begin
                if (mphase[k] == 0) begin
                    if (req_valid[k]) begin
                        mwr[k]    <= req_write[k];
                        maddr[k]  <= req_addr[k];
                        mwd[k]    <= req_wdata[k];
                        mdue[k]   <= cyc + 1 + lat_of(k);
                        mphase[k] <= 1;
                    end
                end else if (mphase[k] == 1) begin
                    if (cyc == mdue[k]) begin
                        mphase[k] <= 2;
                        if ((maddr[k] % 4 != 0) || (maddr[k] / 4 >= 64)) begin
                            merr[k] <= 1'b1;
                            mrd[k]  <= '0;
                        end else begin
                            merr[k] <= 1'b0;
                            if (mwr[k]) begin
                                mmem[k][maddr[k] / 4] <= mwd[k];
                                mrd[k] <= '0;
                            end else begin
                                mrd[k] <= mmem[k][maddr[k] / 4];
                            end
                        end
                    end
                end else if (resp_ready[k]) begin
                    mphase[k] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("cmp%0d req_ready", k), 32'(req_ready[k]), 32'(mphase[k] == 0));
            chk($sformatf("cmp%0d resp_valid", k), 32'(resp_valid[k]), 32'(mphase[k] == 2));
            if (mphase[k] == 2) begin
                chk($sformatf("cmp%0d resp_rdata", k), resp_rdata[k], mrd[k]);
                chk($sformatf("cmp%0d resp_err", k), 32'(resp_err[k]), 32'(merr[k]));
            end
        end
    end

    // Drives one request, scrambles the request inputs after acceptance, then consumes the response.
    task automatic txn(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input bit early, output logic [31:0] rd, output logic e, output int lat);
        chk("txn idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = d;
        resp_ready[k] = early;
        @(posedge clk); #1;
        req_valid[k] = 1'b0; req_write[k] = ~wr; req_addr[k] = ~a; req_wdata[k] = ~d;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (resp_valid[k]) break;
        end
        chk("resp timeout", 32'(resp_valid[k]), 32'd1);
        rd = resp_rdata[k];
        e  = resp_err[k];
        resp_ready[k] = 1'b1;
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
        req_write[k]  = 1'b0;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0; resp_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst req_ready", 32'(req_ready[k]), 32'd1);
            chk("rst resp_valid", 32'(resp_valid[k]), 32'd0);
            chk("rst resp_rdata", resp_rdata[k], 32'd0);
            chk("rst resp_err", 32'(resp_err[k]), 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        txn(0, 1'b0, 32'h4, 32'h0, 1'b0, rd, e, lat);
        chk("load after reset", rd, 32'h0);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, e, lat);
        chk("store latency", 32'(lat), 32'd3);
        chk("store rdata", rd, 32'h0);
        chk("store err", 32'(e), 32'd0);
        chk("model mem", mmem[0][4], 32'hDEADBEEF);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, e, lat);
        chk("load rdata", rd, 32'hDEADBEEF);
        chk("load err", 32'(e), 32'd0);

        txn(0, 1'b1, 32'h13, 32'hFFFFFFFF, 1'b0, rd, e, lat);
        chk("misaligned err", 32'(e), 32'd1);
        chk("misaligned rdata", rd, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, e, lat);
        chk("no write on err", rd, 32'hDEADBEEF);

        txn(0, 1'b0, 32'h100, 32'h0, 1'b0, rd, e, lat);
        chk("oor err", 32'(e), 32'd1);
        chk("oor rdata", rd, 32'h0);
        txn(0, 1'b0, 32'hFC, 32'h0, 1'b0, rd, e, lat);
        chk("top word err", 32'(e), 32'd0);
        chk("top word rdata", rd, 32'h0);

        // Backpressure: response held while req_valid toggles.
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        for (int i = 0; i < 40 && !resp_valid[0]; i++) begin
            @(posedge clk); #1;
        end
        chk("bp resp timeout", 32'(resp_valid[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            req_valid[0] = i[0];
            req_addr[0]  = 32'h20 + 32'(i * 4);
            @(posedge clk); #1;
            chk("bp valid", 32'(resp_valid[0]), 32'd1);
            chk("bp rdata", resp_rdata[0], 32'hDEADBEEF);
            chk("bp err", 32'(resp_err[0]), 32'd0);
            chk("bp req_ready", 32'(req_ready[0]), 32'd0);
        end
        req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        chk("bp release ready", 32'(req_ready[0]), 32'd1);
        chk("bp release valid", 32'(resp_valid[0]), 32'd0);

        // Reset one cycle after acceptance drops the store.
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[0] = 1'b0; req_write[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("wait rst valid", 32'(resp_valid[0]), 32'd0);
        chk("wait rst ready", 32'(req_ready[0]), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("dropped valid", 32'(resp_valid[0]), 32'd0);
        end
        txn(0, 1'b0, 32'h20, 32'h0, 1'b0, rd, e, lat);
        chk("dropped store", rd, 32'h0);

        txn(1, 1'b1, 32'h20, 32'h12345678, 1'b0, rd, e, lat);
        chk("lat0 store latency", 32'(lat), 32'd1);
        chk("lat0 store err", 32'(e), 32'd0);
        txn(1, 1'b0, 32'h20, 32'h0, 1'b1, rd, e, lat);
        chk("lat0 load latency", 32'(lat), 32'd1);
        chk("lat0 load rdata", rd, 32'h12345678);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
